stream_fork: RTL and testbench

Two-way broadcast fork for the valid/ready streaming fabric. It accepts one input beat and delivers an identical copy to each of two independent consumers. Each branch has its own 2-entry buffer, so each consumer drains at its own pace. It sits downstream of the two-operand adder, fanning its 9-bit sum out to two consumers, and is the counterpart of the adder's join.

---
 rtl/stream_fork.sv | 83 ++++++++
 tb/tb_stream_fork.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fork.sv
// stream_fork: two-way broadcast fork. Every accepted input beat is copied
// into a private 2-entry FIFO per branch, so each consumer drains at its own
// pace. Input readiness depends only on registered occupancy (and reset).
module stream_fork #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
);

  // Buffer geometry is hard-wired to two entries (1-bit pointers).
  if (DEPTH != 2) begin : g_depth_check
    $error("stream_fork: DEPTH must be 2");
  end

  // Index 0 is branch A, index 1 is branch B.
  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       cnt [2];
  logic [1:0]       out_ready;
  logic             push;
  logic [1:0]       pop;

  assign out_ready = {b_ready, a_ready};

  // Transfer qualifiers for the input and each branch output.
  always_comb begin
    push = i_valid & i_ready;
    pop  = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      pop[k] = (cnt[k] != 2'd0) & out_ready[k];
    end
  end

  // Per-branch FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        cnt[k]    <= '0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (push) begin
          mem[k][wr_ptr[k]] <= i_data;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        case ({push, pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Heads of each FIFO drive the branch outputs; readiness from occupancy only.
  always_comb begin
    a_valid = (cnt[0] != 2'd0);
    b_valid = (cnt[1] != 2'd0);
    a_data  = mem[0][rd_ptr[0]];
    b_data  = mem[1][rd_ptr[1]];
    i_ready = (cnt[0] != 2'd2) & (cnt[1] != 2'd2) & ~rst;
  end

endmodule

// File: tb/tb_stream_fork.sv
// Bench for stream_fork: queue-based reference model checked every cycle,
// plus directed literal expectations for reset, stall and async-reset cases.
module tb_stream_fork;

  localparam int unsigned WIDTH = 9;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  int checks   = 0;
  int failures = 0;

  stream_fork #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of pending beats per branch.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic             prev_a_stall = 1'b0;
  logic             prev_b_stall = 1'b0;
  logic [WIDTH-1:0] prev_a_data  = '0;
  logic [WIDTH-1:0] prev_b_data  = '0;

  // Inputs only change just after the rising edge, so values seen at the
  // falling edge are exactly those the next rising edge will act on.
  always @(negedge clk) begin
    logic exp_ready;
    logic fire_in;
    if (rst) begin
      qa.delete();
      qb.delete();
      chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_a_data", {23'd0, a_data}, 32'd0);
      chk("rst_b_data", {23'd0, b_data}, 32'd0);
      prev_a_stall = 1'b0;
      prev_b_stall = 1'b0;
    end else begin
      exp_ready = (qa.size() < 2) && (qb.size() < 2);
      chk("i_ready", {31'd0, i_ready}, {31'd0, exp_ready});
      chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
      chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
      if (qa.size() != 0) chk("a_data", {23'd0, a_data}, {23'd0, qa[0]});
      if (qb.size() != 0) chk("b_data", {23'd0, b_data}, {23'd0, qb[0]});
      if (prev_a_stall) chk("a_hold", {22'd0, a_valid, a_data}, {22'd0, 1'b1, prev_a_data});
      if (prev_b_stall) chk("b_hold", {22'd0, b_valid, b_data}, {22'd0, 1'b1, prev_b_data});
      prev_a_stall = a_valid && !a_ready;
      prev_b_stall = b_valid && !b_ready;
      prev_a_data  = a_data;
      prev_b_data  = b_data;
      fire_in = i_valid && exp_ready;
      if (qa.size() != 0 && a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready) void'(qb.pop_front());
      if (fire_in) begin
        qa.push_back(i_data);
        qb.push_back(i_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ready_drops;
  logic rdy_before;

  initial begin
    rst     = 1'b1;
    i_data  = '0;
    i_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;

    // Reset and idle
    tick();
    tick();
    chk("lit_rst_ready", {31'd0, i_ready}, 32'd0);
    chk("lit_rst_avalid", {31'd0, a_valid}, 32'd0);
    chk("lit_rst_bdata", {23'd0, b_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("lit_post_rst_ready", {31'd0, i_ready}, 32'd1);
    chk("lit_post_rst_avalid", {31'd0, a_valid}, 32'd0);

    // Full-rate stream with both consumers ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    ready_drops = 0;
    for (int i = 0; i < 256; i++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'(i);
      tick();
      if (!i_ready) ready_drops++;
      if (i == 0) begin
        chk("lit_stream_first_a", {23'd0, a_data}, 32'h000);
        chk("lit_stream_first_b", {23'd0, b_data}, 32'h000);
      end
      if (i == 5) chk("lit_stream_a5", {23'd0, a_data}, 32'h005);
    end
    chk("lit_stream_ready_drops", ready_drops, 0);
    i_valid = 1'b0;
    tick();
    chk("lit_stream_last_gone", {31'd0, a_valid}, 32'd0);

    // B stalled: A runs ahead, input blocks once B holds two beats
    b_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 9'h101;
    tick();
    chk("lit_st1_a", {23'd0, a_data}, 32'h101);
    chk("lit_st1_ready", {31'd0, i_ready}, 32'd1);
    i_data = 9'h102;
    tick();
    chk("lit_st2_ready", {31'd0, i_ready}, 32'd0);
    chk("lit_st2_a", {23'd0, a_data}, 32'h102);
    chk("lit_st2_b", {23'd0, b_data}, 32'h101);
    i_data = 9'h103;
    tick();
    chk("lit_st3_ready", {31'd0, i_ready}, 32'd0);
    chk("lit_st3_avalid", {31'd0, a_valid}, 32'd0);
    chk("lit_st3_b", {23'd0, b_data}, 32'h101);
    b_ready = 1'b1;
    tick();
    chk("lit_st4_ready", {31'd0, i_ready}, 32'd1);
    chk("lit_st4_b", {23'd0, b_data}, 32'h102);
    tick();
    chk("lit_st5_a", {23'd0, a_data}, 32'h103);
    chk("lit_st5_b", {23'd0, b_data}, 32'h103);
    i_valid = 1'b0;
    tick();
    tick();

    // Random traffic, holding input data stable while not accepted
    for (int c = 0; c < 10000; c++) begin
      a_ready = 1'($urandom_range(0, 3) != 0);
      b_ready = 1'($urandom_range(0, 2) != 0);
      if (!(i_valid && !rdy_before)) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = WIDTH'($urandom);
      end
      rdy_before = i_ready;
      tick();
    end
    i_valid = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    tick();
    tick();

    // Asynchronous reset with both FIFOs full
    a_ready = 1'b0;
    b_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 9'h1AA;
    tick();
    i_data = 9'h155;
    tick();
    i_valid = 1'b0;
    chk("lit_full_ready", {31'd0, i_ready}, 32'd0);
    chk("lit_full_a", {23'd0, a_data}, 32'h1AA);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_arst_ready", {31'd0, i_ready}, 32'd0);
    chk("lit_arst_avalid", {31'd0, a_valid}, 32'd0);
    chk("lit_arst_bvalid", {31'd0, b_valid}, 32'd0);
    chk("lit_arst_adata", {23'd0, a_data}, 32'd0);
    chk("lit_arst_bdata", {23'd0, b_data}, 32'd0);
    tick();
    rst = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    chk("lit_arst_no_stale_a", {31'd0, a_valid}, 32'd0);
    chk("lit_arst_no_stale_b", {31'd0, b_valid}, 32'd0);
    tick();

    // Alternating extremes
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1;
      i_data  = (i % 2 == 0) ? 9'h1FF : 9'h000;
      tick();
      if (i == 0) begin
        chk("lit_max_a", {23'd0, a_data}, 32'h1FF);
        chk("lit_max_b", {23'd0, b_data}, 32'h1FF);
      end
      if (i == 1) chk("lit_min_b", {23'd0, b_data}, 32'h000);
    end
    i_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial rdy_before = 1'b0;

endmodule
